// File: rtl/rle_pkg.sv
// Shared constants, FSM encoding and the JPEG zigzag-to-raster table for the
// run-length decode path (also intended for a future zigzag stage in encode).
package rle_pkg;

    localparam int COEF_W  = 8;
    localparam int N_COEF  = 64;
    localparam int N_PAIRS = 32;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    // Entry i is the raster position (row*8+col) of zigzag index i.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/rle_decode_zigzag_lut.sv
// Combinational zigzag-index to raster-index lookup.
module zigzag_lut
    import rle_pkg::*;
(
    input  logic [5:0] zz_idx,
    output logic [5:0] raster_idx
);

    assign raster_idx = ZIGZAG[zz_idx];

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: rebuilds one 8x8 block of signed coefficients in raster
// order from up to 32 (run, level) pairs, one pair per clock.
module rle_decode
    import rle_pkg::*;
#(
    parameter int COEF_W  = rle_pkg::COEF_W,
    parameter int N_COEF  = rle_pkg::N_COEF,
    parameter int N_PAIRS = rle_pkg::N_PAIRS
) (
    input  logic                              Clock,
    input  logic                              reset,
    input  logic                              Enable,
    input  logic [N_PAIRS*2*COEF_W-1:0]       A,
    output logic signed [N_COEF*COEF_W-1:0]   C,
    output logic                              done,
    output logic                              error
);

    localparam int PW = 2 * COEF_W;
    localparam int AW = $clog2(N_PAIRS * PW);
    localparam int CW = $clog2(N_COEF * COEF_W);

    state_t state_q, state_d;

    logic [6:0]             k;
    logic [5:0]             j;
    logic [N_PAIRS*PW-1:0]  areg;

    logic [AW-1:0]          pair_base;
    logic [PW-1:0]          pair;
    logic [COEF_W-1:0]      run;
    logic signed [COEF_W-1:0] level;
    logic [6:0]             t;
    logic [5:0]             raster;
    logic [CW-1:0]          c_base;
    logic                   eob;

    logic start, wr, err_set;

    assign pair_base = AW'(j) * AW'(PW);
    assign pair      = areg[pair_base +: PW];
    assign run       = pair[PW-1 -: COEF_W];
    assign level     = pair[COEF_W-1:0];
    assign eob       = (run == '0) && (level == '0);

    // Deliberately 7-bit: the overflow test is on this truncated sum.
    assign t         = k + 7'(run);

    zigzag_lut u_zigzag_lut (
        .zz_idx     (t[5:0]),
        .raster_idx (raster)
    );

    assign c_base = CW'(raster) * CW'(COEF_W);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr      = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (Enable) begin
                    start   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else if (eob) begin
                    state_d = DONE;
                end else if (t > 7'd63) begin
                    err_set = 1'b1;
                    state_d = DONE;
                end else begin
                    wr = 1'b1;
                    if ((t == 7'd63) || (j == 6'(N_PAIRS - 1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!Enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero runs need no writes: C is cleared on start.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q <= IDLE;
            C       <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            k       <= '0;
            j       <= '0;
            areg    <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == DONE);
            if (start) begin
                areg  <= A;
                C     <= '0;
                k     <= '0;
                j     <= '0;
                error <= 1'b0;
            end
            if (err_set) begin
                error <= 1'b1;
            end
            if (wr) begin
                C[c_base +: COEF_W] <= level;
                k <= t + 7'd1;
                j <= j + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode with a reference decoder feeding a scoreboard.
module tb_rle_decode;

    logic         Clock = 1'b0;
    logic         reset;
    logic         Enable;
    logic [511:0] A;
    logic signed [511:0] C;
    logic         done;
    logic         error;

    always #5 Clock = ~Clock;

    rle_decode dut (
        .Clock  (Clock),
        .reset  (reset),
        .Enable (Enable),
        .A      (A),
        .C      (C),
        .done   (done),
        .error  (error)
    );

    typedef struct {
        logic [511:0] c;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           passes = 0;
    int           fails  = 0;
    int           zz_tab[64];
    logic [511:0] last_c;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] a, input int j, input int run, input int lvl);
        logic [8:0] b;
        b = 9'(16 * j);
        a[b +: 8]         = 8'(lvl);
        a[b + 9'd8 +: 8]  = 8'(run);
        return a;
    endfunction

    // Reference decoder, built from the algorithmic description of the block.
    function automatic exp_t model(input logic [511:0] a);
        exp_t       e;
        int         k;
        int         t;
        logic [8:0] b;
        logic [7:0] r8;
        logic [7:0] l8;
        e.c   = '0;
        e.err = 1'b0;
        e.lat = 0;
        k     = 0;
        for (int jj = 0; jj < 32; jj++) begin
            b  = 9'(16 * jj);
            l8 = a[b +: 8];
            r8 = a[b + 9'd8 +: 8];
            e.lat = jj + 1;
            if (r8 == 8'd0 && l8 == 8'd0) return e;
            t = (k + int'(r8)) % 128;
            if (t > 63) begin
                e.err = 1'b1;
                return e;
            end
            e.c[9'(8 * zz_tab[t]) +: 8] = l8;
            k = t + 1;
            if (t == 63) return e;
        end
        return e;
    endfunction

    task automatic run_block(input logic [511:0] a, input string tag);
        exp_t e;
        int   n;
        exp_q.push_back(model(a));
        A      = a;
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        A = ~a;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge Clock);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        check({tag, "_done"}, 512'(done), 512'(1));
        check({tag, "_latency"}, 512'(n), 512'(e.lat));
        check({tag, "_C"}, C, e.c);
        check({tag, "_error"}, 512'(error), 512'(e.err));
        last_c = C;
        @(posedge Clock);
        #1;
        check({tag, "_hold_done"}, 512'(done), 512'(1));
        check({tag, "_hold_C"}, C, e.c);
        Enable = 1'b0;
        @(posedge Clock);
        #1;
        check({tag, "_release_done"}, 512'(done), 512'(0));
        check({tag, "_release_C"}, C, e.c);
    endtask

    initial begin
        logic [511:0] a;
        int           idx;
        int           np;

        // Build the zigzag map by walking anti-diagonals.
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_tab[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_tab[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end

        reset  = 1'b0;
        Enable = 1'b0;
        A      = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_C", C, '0);
        check("reset_done", 512'(done), 512'(0));
        check("reset_error", 512'(error), 512'(0));
        reset = 1'b1;
        @(posedge Clock);
        #1;

        // Basic block
        a = '0;
        a = put(a, 0, 0, 9);
        a = put(a, 1, 0, 3);
        a = put(a, 2, 2, -1);
        run_block(a, "basic");
        check("basic_r0", 512'(last_c[0 +: 8]), 512'(8'd9));
        check("basic_r1", 512'(last_c[8 +: 8]), 512'(8'd3));
        check("basic_r9", 512'(last_c[72 +: 8]), 512'(8'hFF));
        check("basic_r2", 512'(last_c[16 +: 8]), 512'(8'd0));

        // EOB first: later pairs must be ignored
        a = put('0, 1, 0, 4);
        run_block(a, "eob_first");
        check("eob_first_zero", last_c, '0);

        // Full block ending on coefficient 63
        a = '0;
        a = put(a, 0, 0, 5);
        a = put(a, 1, 62, -7);
        a = put(a, 2, 0, 6);
        run_block(a, "full");
        check("full_r0", 512'(last_c[0 +: 8]), 512'(8'd5));
        check("full_r63", 512'(last_c[504 +: 8]), 512'(8'hF9));

        // Overflow
        a = '0;
        a = put(a, 0, 64, 1);
        a = put(a, 1, 0, 3);
        run_block(a, "overflow");
        check("overflow_err", 512'(error), 512'(1));
        check("overflow_zero", last_c, '0);

        // Pair exhaustion
        a = '0;
        for (int p = 0; p < 32; p++) a = put(a, p, 0, 1);
        run_block(a, "exhaust");
        check("exhaust_r16", 512'(last_c[128 +: 8]), 512'(8'd1));
        check("exhaust_r2", 512'(last_c[16 +: 8]), 512'(8'd1));
        check("exhaust_r63", 512'(last_c[504 +: 8]), 512'(8'd0));

        // Abort after two decode edges
        a = '0;
        for (int p = 0; p < 32; p++) a = put(a, p, 0, 2);
        A      = a;
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        repeat (2) @(posedge Clock);
        #1;
        Enable = 1'b0;
        @(posedge Clock);
        #1;
        check("abort_done", 512'(done), 512'(0));
        @(posedge Clock);
        #1;
        check("abort_done_later", 512'(done), 512'(0));
        check("abort_error", 512'(error), 512'(0));

        // Clean decodes of fresh random blocks after the abort
        for (int b = 0; b < 3; b++) begin
            a  = '0;
            np = $urandom_range(1, 24);
            for (int p = 0; p < np; p++) a = put(a, p, $urandom_range(0, 4), $urandom_range(1, 255));
            run_block(a, $sformatf("random%0d", b));
        end

        // Reset in the middle of a decode
        a = '0;
        for (int p = 0; p < 32; p++) a = put(a, p, 0, 3);
        A      = a;
        Enable = 1'b1;
        @(posedge Clock);
        #1;
        repeat (3) @(posedge Clock);
        #1;
        reset = 1'b0;
        @(posedge Clock);
        #1;
        check("midreset_C", C, '0);
        check("midreset_done", 512'(done), 512'(0));
        check("midreset_error", 512'(error), 512'(0));
        reset  = 1'b1;
        Enable = 1'b0;
        @(posedge Clock);
        #1;

        a = '0;
        a = put(a, 0, 3, 11);
        a = put(a, 1, 1, -2);
        run_block(a, "after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
